// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline front end: widths, reset constants,
// the IF/ID bundle and the word-alignment helper.
package pipe_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    localparam logic [ADDR_W-1:0] PIPE_RESET_PC = 32'h0000_0000;
    localparam logic [INST_W-1:0] PIPE_NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              valid;
    } if_id_t;

    typedef enum logic [1:0] {
        ID_CLEAR  = 2'd0,
        ID_HOLD   = 2'd1,
        ID_BUBBLE = 2'd2,
        ID_LOAD   = 2'd3
    } id_action_t;

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold/bubble control and accepted-fetch counter.
module if_id_reg
    import pipe_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = PIPE_NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              flush,
    input  logic              rom_ce,
    input  logic [ADDR_W-1:0] pc,
    input  logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o,
    output logic [31:0]       fetch_count_o
);

    if_id_t     id_r;
    if_id_t     bubble_s;
    logic [31:0] count_r;
    id_action_t action_s;

    assign bubble_s = '{pc: 32'h0000_0000, inst: NOP_INST, valid: 1'b0};

    // Classify this edge's IF/ID update
    always_comb begin
        action_s = ID_LOAD;
        if (flush) begin
            action_s = ID_CLEAR;
        end else if (stall_id) begin
            action_s = ID_HOLD;
        end else if (stall_if || !rom_ce) begin
            action_s = ID_BUBBLE;
        end else begin
            action_s = ID_LOAD;
        end
    end

    // Pipeline register and counter; flush clears the register but not the count
    always_ff @(posedge clk) begin
        if (rst) begin
            id_r    <= bubble_s;
            count_r <= 32'd0;
        end else begin
            case (action_s)
                ID_CLEAR:  id_r <= bubble_s;
                ID_HOLD:   id_r <= id_r;
                ID_BUBBLE: id_r <= bubble_s;
                ID_LOAD: begin
                    id_r    <= '{pc: pc, inst: inst, valid: 1'b1};
                    count_r <= count_r + 32'd1;
                end
                default:   id_r <= bubble_s;
            endcase
        end
    end

    assign id_pc_o       = id_r.pc;
    assign id_inst_o     = id_r.inst;
    assign id_valid_o    = id_r.valid;
    assign fetch_count_o = count_r;

endmodule

// File: rtl/pc_reg.sv
// Program counter and ROM chip-enable sequencing with the next-PC priority mux.
module pc_reg
    import pipe_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = PIPE_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic              ce_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] next_pc_s;
    logic              hold_pc_s;

    // stall_id alone must also freeze the PC, so fold it into the hold
    assign hold_pc_s = stall_if | stall_id;

    // Next-PC selection: flush beats hold, hold drops a pending branch
    always_comb begin
        next_pc_s = pc_r;
        if (!ce_r) begin
            next_pc_s = RESET_PC;
        end else if (flush) begin
            next_pc_s = align_word(new_pc);
        end else if (hold_pc_s) begin
            next_pc_s = pc_r;
        end else if (branch_flag) begin
            next_pc_s = align_word(branch_target);
        end else begin
            next_pc_s = pc_r + 32'd4;
        end
    end

    // PC and chip-enable state; ce rises on the first edge out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_r <= 1'b0;
            pc_r <= RESET_PC;
        end else begin
            ce_r <= 1'b1;
            pc_r <= next_pc_s;
        end
    end

    assign rom_ce_o = ce_r;
    assign pc_o     = pc_r;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: wires the PC sequencer to the IF/ID register.
module if_stage
    import pipe_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = PIPE_RESET_PC,
    parameter logic [INST_W-1:0] NOP_INST = PIPE_NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [INST_W-1:0] inst_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o,
    output logic [31:0]       fetch_count_o
);

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .rst          (rst),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .flush        (flush),
        .new_pc       (new_pc),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .rom_ce_o     (rom_ce_o),
        .pc_o         (pc_o)
    );

    if_id_reg #(
        .NOP_INST(NOP_INST)
    ) u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .flush        (flush),
        .rom_ce       (rom_ce_o),
        .pc           (pc_o),
        .inst         (inst_i),
        .id_pc_o      (id_pc_o),
        .id_inst_o    (id_inst_o),
        .id_valid_o   (id_valid_o),
        .fetch_count_o(fetch_count_o)
    );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed test-plan sequence with literal expectations,
// then randomized control traffic checked every cycle against a reference model.
module tb_if_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall_if, stall_id, flush, branch_flag;
    logic [31:0] new_pc, branch_target, inst_i;
    logic        rom_ce_o, id_valid_o;
    logic [31:0] pc_o, id_pc_o, id_inst_o, fetch_count_o;

    logic [31:0] rom [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign inst_i = rom[pc_o[9:2]];

    if_stage dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
        .flush(flush), .new_pc(new_pc), .branch_flag(branch_flag),
        .branch_target(branch_target), .inst_i(inst_i), .rom_ce_o(rom_ce_o),
        .pc_o(pc_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
        .id_valid_o(id_valid_o), .fetch_count_o(fetch_count_o)
    );

    typedef struct {
        bit          ce;
        logic [31:0] pc;
        logic [31:0] id_pc;
        logic [31:0] id_inst;
        bit          id_valid;
        logic [31:0] cnt;
    } model_t;

    model_t m;
    bit     started = 1'b0;

    // Architectural view of one clock edge
    function automatic model_t step(model_t s, bit r, bit sif, bit sid, bit fl,
                                    logic [31:0] npc, bit br, logic [31:0] tgt);
        model_t n = s;
        if (r) begin
            n.ce = 0; n.pc = 32'h0; n.id_pc = 32'h0; n.id_inst = 32'h0;
            n.id_valid = 0; n.cnt = 32'h0;
            return n;
        end
        n.ce = 1;
        if (!s.ce)            n.pc = 32'h0;
        else if (fl)          n.pc = npc & 32'hFFFF_FFFC;
        else if (sif || sid)  n.pc = s.pc;
        else if (br)          n.pc = tgt & 32'hFFFF_FFFC;
        else                  n.pc = s.pc + 32'd4;
        if (fl || (!sid && (sif || !s.ce))) begin
            n.id_pc = 32'h0; n.id_inst = 32'h0; n.id_valid = 0;
        end else if (!sid) begin
            n.id_pc = s.pc; n.id_inst = rom[s.pc[9:2]]; n.id_valid = 1;
            n.cnt = s.cnt + 32'd1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m       <= step(m, rst, stall_if, stall_id, flush, new_pc, branch_flag, branch_target);
        started <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("model rom_ce", {31'd0, rom_ce_o}, {31'd0, m.ce});
            chk("model pc", pc_o, m.pc);
            chk("model id_pc", id_pc_o, m.id_pc);
            chk("model id_inst", id_inst_o, m.id_inst);
            chk("model id_valid", {31'd0, id_valid_o}, {31'd0, m.id_valid});
            chk("model count", fetch_count_o, m.cnt);
        end
    end

    task automatic idle();
        rst = 0; stall_if = 0; stall_id = 0; flush = 0; branch_flag = 0;
        new_pc = 32'h0; branch_target = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[0] = 32'h0000_0000;
        rom[1] = 32'h0001_1080;
        rom[2] = 32'h3C01_0001;

        idle();
        rst = 1;
        repeat (3) tick();
        chk("reset ce", {31'd0, rom_ce_o}, 32'd0);
        chk("reset valid", {31'd0, id_valid_o}, 32'd0);
        chk("reset count", fetch_count_o, 32'd0);

        rst = 0;
        tick();
        chk("first ce", {31'd0, rom_ce_o}, 32'd1);
        chk("first pc", pc_o, 32'h0);
        chk("first valid", {31'd0, id_valid_o}, 32'd0);
        tick();
        chk("seq pc4", pc_o, 32'h4);
        chk("seq id_pc0", id_pc_o, 32'h0);
        chk("seq valid", {31'd0, id_valid_o}, 32'd1);
        tick();
        chk("seq inst1", id_inst_o, 32'h0001_1080);
        tick();
        chk("seq pcC", pc_o, 32'hC);
        chk("seq inst2", id_inst_o, 32'h3C01_0001);
        chk("seq id_pc8", id_pc_o, 32'h8);
        chk("seq count3", fetch_count_o, 32'd3);
        tick();
        chk("pc at 0x10", pc_o, 32'h10);

        branch_flag = 1; branch_target = 32'h42;
        tick();
        chk("branch pc", pc_o, 32'h40);
        chk("delay slot id_pc", id_pc_o, 32'h10);
        branch_target = 32'h20;
        tick();
        idle();
        chk("pc at 0x20", pc_o, 32'h20);

        stall_if = 1; stall_id = 1; branch_flag = 1; branch_target = 32'h100;
        repeat (2) tick();
        chk("stall pc", pc_o, 32'h20);
        chk("stall id_pc", id_pc_o, 32'h40);
        chk("stall count", fetch_count_o, 32'd6);
        stall_id = 0; branch_flag = 0;
        tick();
        chk("bubble valid", {31'd0, id_valid_o}, 32'd0);
        chk("bubble inst", id_inst_o, 32'h0);
        chk("bubble pc", pc_o, 32'h20);

        stall_if = 1; flush = 1; new_pc = 32'h182; branch_flag = 1; branch_target = 32'h300;
        tick();
        idle();
        chk("flush pc", pc_o, 32'h180);
        chk("flush valid", {31'd0, id_valid_o}, 32'd0);
        chk("flush count", fetch_count_o, 32'd6);
        tick();
        chk("after flush id_pc", id_pc_o, 32'h180);

        branch_flag = 1; branch_target = 32'hFFFF_FFFF;
        tick();
        idle();
        chk("near wrap pc", pc_o, 32'hFFFF_FFFC);
        tick();
        chk("wrap pc", pc_o, 32'h0);
        chk("wrap id_pc", id_pc_o, 32'hFFFF_FFFC);

        rst = 1;
        tick();
        rst = 0;
        chk("midrst ce", {31'd0, rom_ce_o}, 32'd0);
        chk("midrst pc", pc_o, 32'h0);
        chk("midrst count", fetch_count_o, 32'd0);
        chk("midrst id_pc", id_pc_o, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(99) == 0);
            flush         = ($urandom_range(15) == 0);
            stall_if      = ($urandom_range(4) == 0);
            stall_id      = ($urandom_range(7) == 0);
            branch_flag   = ($urandom_range(5) == 0);
            new_pc        = $urandom;
            branch_target = ($urandom_range(9) == 0) ? 32'hFFFF_FFF0 + {28'd0, 4'($urandom)}
                                                     : {22'd0, 10'($urandom)};
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM chip-enable and address.
- Captures the ROM's combinational instruction into the IF/ID pipeline register for the decode stage.
- Handles sequential fetch, taken branches/jumps (MIPS delay-slot semantics), hazard-unit stalls and exception flushes.

Parameters:
- RESET_PC, 32'h0000_0000: PC value after reset.
- NOP_INST, 32'h0000_0000: instruction word inserted as a bubble (sll $0,$0,0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- stall_if  input  1  hazard unit: hold PC.
- stall_id  input  1  hazard unit: hold IF/ID register.
- flush  input  1  exception/eret redirect; highest priority after rst.
- new_pc  input  32  flush target.
- branch_flag  input  1  decode stage: branch/jump taken.
- branch_target  input  32  decode-stage target address.
- inst_i  input  32  instruction word returned by ROM for the current pc_o.
- rom_ce_o  output  1  ROM chip-enable.
- pc_o  output  32  ROM address (current fetch PC).
- id_pc_o  output  32  PC of the instruction in IF/ID.
- id_inst_o  output  32  instruction in IF/ID.
- id_valid_o  output  1  1 = id_inst_o is a real fetched instruction; 0 = bubble.
- fetch_count_o  output  32  number of instructions accepted into IF/ID since reset.

Behaviour:
- Reset values:
  - rom_ce_o=0, pc_o=RESET_PC.
  - id_pc_o=0, id_inst_o=NOP_INST, id_valid_o=0.
  - fetch_count_o=0.
- Chip-enable sequencing:
  - rom_ce_o goes to 1 on the first clk edge with rst=0, and stays 1 until the next reset.
  - While rom_ce_o=0, pc_o stays at RESET_PC.
  - First fetch is therefore at RESET_PC, one cycle after reset release.
- The ROM is combinational: inst_i is valid in the same cycle as pc_o. Fetch latency from PC to IF/ID is one edge.
- Effective PC hold: hold_pc = stall_if | stall_id. The hazard unit guarantees stall_id implies stall_if; the block enforces this internally regardless.
- Next-PC priority, evaluated each edge when rom_ce_o=1:
  1. rst -> RESET_PC.
  2. flush -> {new_pc[31:2],2'b00}.
  3. hold_pc -> unchanged.
  4. branch_flag -> {branch_target[31:2],2'b00}.
  5. Otherwise pc_o+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- PC alignment: pc_o[1:0] is always 00.
- Delay slot:
  - When branch_flag is seen, the instruction currently in IF is the delay slot. It is captured into IF/ID normally and is not squashed.
  - The target is fetched on the following cycle.
- IF/ID update priority per edge:
  1. rst or flush -> id_inst_o=NOP_INST, id_pc_o=0, id_valid_o=0.
  2. stall_id -> hold all three.
  3. stall_if (with stall_id=0) -> bubble: NOP_INST, id_pc_o=0, id_valid_o=0.
  4. rom_ce_o=0 -> bubble.
  5. Otherwise id_inst_o=inst_i, id_pc_o=pc_o, id_valid_o=1.
- fetch_count_o:
  - Increments by 1 exactly when case 5 occurs.
  - Wraps modulo 2^32.
  - Cleared only by rst; unaffected by flush.
- Simultaneous events:
  - flush with branch_flag: flush wins.
  - flush with stalls: flush wins for both PC and IF/ID.
  - branch_flag under hold_pc is dropped. The decode stage re-asserts it while the branch remains in ID.
- rst asserted mid-operation: all state returns to reset values on that edge, and rom_ce_o drops to 0 for at least one cycle.

Decomposition:
- Shared package pipe_pkg:
  - RESET_PC and NOP_INST constants.
  - Instruction-word and address widths (32).
  - IF/ID bundle typedef {pc, inst, valid}.
- Two natural sub-modules:
  - pc_reg: PC and ce sequencing, next-PC mux.
  - if_id_reg: pipeline register, bubble/hold logic, fetch counter.
- if_stage instantiates both and contains only wiring.

Test Plan:
- Reset/ce: rst=1 for 3 cycles, then 0 -> cycle 1: rom_ce_o=1, pc_o=0; next edges pc_o=4,8,C; id_pc_o lags by one edge; id_valid_o=1 from the second edge.
- Sequential capture: ROM holds 0x00000000, 0x00011080, 0x3C010001 at words 0..2 -> id_inst_o sequences through them with id_pc_o=0,4,8; fetch_count_o=3.
- Branch with delay slot: branch_flag=1 for one cycle while pc_o=0x10, branch_target=0x42 -> IF/ID next gets pc 0x10 (delay slot); pc_o becomes 0x40, not 0x14.
- Stalls: stall_if=stall_id=1 for 2 cycles at pc_o=0x20 -> pc_o and IF/ID held, count frozen. stall_if=1, stall_id=0 for 1 cycle -> IF/ID bubble (NOP, valid=0), pc_o stays 0x20.
- Flush priority: flush=1, new_pc=0x180, branch_flag=1, stall_if=1 in the same cycle -> pc_o=0x180, IF/ID bubble; next edge captures pc 0x180.
- Wrap and mid-run reset: force pc_o=0xFFFFFFFC -> next pc_o=0. rst pulse mid-run -> all outputs return to reset values and fetch_count_o=0.
